// File: rtl/core_v_verif_fpga_top.sv
// Single-clock core harness: tick-enabled WAIT/RUN/DONE sequencer that steps a 16x32 RV32I ROM through a legality decoder and shows status on LEDs.
// Define FAULT_INJECT_EN to force ROM word FAULT_INDEX to 0x00000000 (an illegal encoding).

module core_v_verif_fpga_decode (
  input  logic [31:0] word,
  output logic        legal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode        = word[6:0];
  assign funct3        = word[14:12];
  assign funct7        = word[31:25];
  assign unused_fields = ^{word[24:15], word[11:7]};

  // NOTE: default assignment first so every path drives legal; no latch.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      7'b0110111, 7'b0010111, 7'b1101111: legal = 1'b1;
      7'b1100111: legal = (funct3 == 3'b000);
      7'b1100011: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      7'b0000011: legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                          (funct3 == 3'b100) || (funct3 == 3'b101);
      7'b0100011: legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      7'b0010011: begin
        if (funct3 == 3'b001)      legal = (funct7 == 7'b0000000);
        else if (funct3 == 3'b101) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                       legal = 1'b1;
      end
      7'b0110011: legal = (funct7 == 7'b0000000) ||
                          ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      7'b0001111, 7'b1110011: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

module core_v_verif_fpga_top #(
  parameter int unsigned CLK_DIV        = 4,
  parameter int unsigned RST_HOLD_TICKS = 4,
  parameter int unsigned FAULT_INDEX    = 5
) (
  input  logic       clk_nexys_board_i,
  input  logic       rst_sw_i,
  output logic [7:0] led_o
);

  localparam logic [7:0]  DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0]  HOLD_LAST = 8'(RST_HOLD_TICKS - 1);
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  if ((CLK_DIV < 2) || (CLK_DIV > 255) || (RST_HOLD_TICKS < 1) || (RST_HOLD_TICKS > 255) ||
      (FAULT_INDEX > 15)) begin : g_bad_param
    $error("core_v_verif_fpga_top: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_WAIT,
    S_RUN,
    S_DONE_OK,
    S_DONE_ILL
  } state_t;

  state_t      state;
  logic [7:0]  div;
  logic [7:0]  wait_cnt;
  logic [3:0]  pc;
  logic [3:0]  pc_inc;
  logic        tick;
  logic [31:0] word;
  logic        legal;

  function automatic logic [31:0] rom_word(input logic [3:0] addr);
    case (addr)
      4'd0:    return 32'h0050_0093;
      4'd1:    return 32'h00A0_0113;
      4'd2:    return 32'h0020_81B3;
      4'd3:    return 32'h4020_8233;
      4'd4:    return 32'h0031_2023;
      4'd5:    return 32'h0001_2283;
      4'd6:    return 32'h0000_0297;
      4'd7:    return 32'h1234_52B7;
      4'd15:   return EBREAK;
      default: return 32'h0000_0013;
    endcase
  endfunction

`ifdef FAULT_INJECT_EN
  localparam logic [3:0] FAULT_PC = 4'(FAULT_INDEX);
  assign word = (pc == FAULT_PC) ? 32'h0000_0000 : rom_word(pc);
`else
  assign word = rom_word(pc);
`endif

  assign tick   = (div == DIV_LAST);
  assign pc_inc = pc + 4'd1;

  core_v_verif_fpga_decode u_decode (
    .word  (word),
    .legal (legal)
  );

  // LED fields are written alongside the state they mirror, so they change on the same tick edge.
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk_nexys_board_i) begin
    if (!rst_sw_i) begin
      div      <= '0;
      wait_cnt <= '0;
      pc       <= '0;
      state    <= S_WAIT;
      led_o    <= '0;
    end else begin
      div <= tick ? '0 : div + 8'd1;
      if (tick) begin
        led_o[0] <= ~led_o[0];
        case (state)
          S_WAIT: begin
            if (wait_cnt == HOLD_LAST) begin
              state      <= S_RUN;
              pc         <= '0;
              led_o[1]   <= 1'b1;
              led_o[4:2] <= 3'b000;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          S_RUN: begin
            if (!legal) begin
              state    <= S_DONE_ILL;
              led_o[1] <= 1'b0;
              led_o[5] <= 1'b1;
              led_o[7] <= 1'b1;
            end else if (word == EBREAK) begin
              state    <= S_DONE_OK;
              led_o[1] <= 1'b0;
              led_o[6] <= 1'b1;
              led_o[7] <= 1'b1;
            end else begin
              pc         <= pc_inc;
              led_o[4:2] <= pc_inc[2:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_core_v_verif_fpga_top.sv
// Scoreboard bench for core_v_verif_fpga_top: stimulus queues expected LED/decoder values keyed by edge number, a monitor compares them on the falling edge.

module tb_core_v_verif_fpga_top;

`ifdef FAULT_INJECT_EN
  localparam int unsigned DONE_EDGE = 40;
  localparam logic [7:0]  PRE_LED   = 8'h17;
  localparam logic [7:0]  DONE_LED  = 8'hB4;
  localparam logic [7:0]  MID_LED   = 8'hB4;
  localparam logic [7:0]  DONE_BIT  = 8'h20;
`else
  localparam int unsigned DONE_EDGE = 80;
  localparam logic [7:0]  PRE_LED   = 8'h1F;
  localparam logic [7:0]  DONE_LED  = 8'hDC;
  localparam logic [7:0]  MID_LED   = 8'h02;
  localparam logic [7:0]  DONE_BIT  = 8'h40;
`endif

  typedef struct {
    string       name;
    int unsigned at;
    bit          is_dec;
    logic [7:0]  mask;
    logic [7:0]  exp;
  } exp_t;

  logic        clk    = 1'b0;
  logic        rst_sw = 1'b0;
  logic [7:0]  led;
  logic [31:0] dec_word = 32'h0;
  logic        dec_legal;

  int unsigned gedge    = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb[$];

  core_v_verif_fpga_top dut (
    .clk_nexys_board_i (clk),
    .rst_sw_i          (rst_sw),
    .led_o             (led)
  );

  core_v_verif_fpga_decode u_dec (
    .word  (dec_word),
    .legal (dec_legal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) gedge <= gedge + 1;

  task automatic check(input string name, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (edge %0d)", name, actual, expected, gedge);
    end
  endtask

  // Monitor: compare every queued expectation due at the current edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() != 0 && sb[0].at <= gedge) begin
        e = sb.pop_front();
        if (e.at != gedge) begin
          n_checks++;
          n_errors++;
          $display("FAIL %s: sample edge %0d missed (now %0d)", e.name, e.at, gedge);
        end else if (e.is_dec) begin
          check(e.name, {7'b0, dec_legal}, e.exp);
        end else begin
          check(e.name, led & e.mask, e.exp & e.mask);
        end
      end
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_led(input string name, input int unsigned at, input logic [7:0] mask,
                            input logic [7:0] exp);
    exp_t e;
    e.name = name; e.at = at; e.is_dec = 1'b0; e.mask = mask; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic expect_dec(input string name, input logic [31:0] w, input bit legal);
    exp_t e;
    wait_edges(1);
    dec_word = w;
    e.name = name; e.at = gedge; e.is_dec = 1'b1; e.mask = 8'h01; e.exp = {7'b0, legal};
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) wait_edges(1);
    if (sb.size() != 0) begin
      n_checks += sb.size();
      n_errors += sb.size();
      $display("FAIL drain_timeout: %0d expectations pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation ran past 50000 cycles, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;
    int unsigned e1;
    int unsigned e2;

    // Full run out of a long reset.
    wait_edges(3);
    expect_led("reset_hold", gedge, 8'hFF, 8'h00);
    wait_edges(497);
    e0 = gedge;
    rst_sw = 1'b1;
    expect_led("pre_first_tick", e0 + 3,             8'hFF, 8'h00);
    expect_led("hb_tick1",       e0 + 4,             8'hFF, 8'h01);
    expect_led("hb_tick2",       e0 + 8,             8'hFF, 8'h00);
    expect_led("hb_tick3",       e0 + 12,            8'hFF, 8'h01);
    expect_led("wait_edge15",    e0 + 15,            8'hFF, 8'h01);
    expect_led("run_entry",      e0 + 16,            8'hFF, 8'h02);
    expect_led("first_step",     e0 + 20,            8'hFF, 8'h07);
    expect_led("pre_done",       e0 + DONE_EDGE - 1, 8'hFF, PRE_LED);
    expect_led("done",           e0 + DONE_EDGE,     8'hFF, DONE_LED);
    expect_led("done_hb",        e0 + DONE_EDGE + 4, 8'hFF, DONE_LED | 8'h01);
    expect_led("done_sticky",    e0 + 200,           8'hFF, DONE_LED);
    wait_edges(200);
    drain();

    // Reset mid-run, then a clean restart.
    rst_sw = 1'b0;
    wait_edges(5);
    e1 = gedge;
    rst_sw = 1'b1;
    expect_led("mid_run",      e1 + 48, 8'hFF, MID_LED);
    expect_led("mid_reset",    e1 + 50, 8'hFF, 8'h00);
    expect_led("mid_reset_2",  e1 + 51, 8'hFF, 8'h00);
    wait_edges(49);
    rst_sw = 1'b0;
    wait_edges(3);
    e2 = gedge;
    rst_sw = 1'b1;
    expect_led("rerun_pre",  e2 + DONE_EDGE - 1, DONE_BIT, 8'h00);
    expect_led("rerun_done", e2 + DONE_EDGE,     8'hFF,    DONE_LED);
    drain();

    // Decoder vectors.
    expect_dec("dec_addi_nop", 32'h0000_0013, 1'b1);
    expect_dec("dec_sub",      32'h4020_8233, 1'b1);
    expect_dec("dec_ebreak",   32'h0010_0073, 1'b1);
    expect_dec("dec_srai",     32'h4000_5013, 1'b1);
    expect_dec("dec_zero",     32'h0000_0000, 1'b0);
    expect_dec("dec_707f",     32'h0000_707F, 1'b0);
    expect_dec("dec_mul",      32'h0220_8033, 1'b0);
    expect_dec("dec_jalr_f3",  32'h0000_2067, 1'b0);
    expect_dec("dec_slli_f7",  32'h4000_1013, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/core_v_verif_fpga_top.md
CORE_V_VERIF_FPGA_TOP -- requirements
Module: core_v_verif_fpga_top

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: the number of clocks per core tick, with legal range 2..255.
REQ-002 The block SHALL have parameter RST_HOLD_TICKS, default 4: the number of core ticks spent in WAIT after reset release, with legal range 1..255.
REQ-003 The block SHALL have parameter FAULT_INDEX, default 5: the ROM word index replaced when fault injection is enabled, with legal range 0..15.
REQ-004 Port clk_nexys_board_i SHALL be an input, 1 bit wide, and be the single clock; all flops are rising-edge on this clock.
REQ-005 Port rst_sw_i SHALL be an input, 1 bit wide: a synchronous, active-low reset.
REQ-006 Port led_o SHALL be an output, 8 bits wide, carrying the status LEDs defined in REQ-014.

Function
REQ-007 The block SHALL use one clock only; the slow core clock SHALL be a 1-cycle tick enable, never a derived clock.
REQ-008 The divider counter SHALL count 0..CLK_DIV-1 and wrap; tick SHALL be high when counter == CLK_DIV-1; the first tick SHALL be on the CLK_DIV-th edge after reset release.
REQ-009 The block SHALL contain a fixed 16x32 instruction ROM with the following contents:
- [0]=0x00500093, [1]=0x00A00113, [2]=0x002081B3, [3]=0x40208233;
- [4]=0x00312023, [5]=0x00012283, [6]=0x00000297, [7]=0x123452B7;
- [8..14]=0x00000013;
- [15]=0x00100073 (EBREAK).
REQ-010 The state machine SHALL have four states: WAIT -> RUN -> DONE_OK | DONE_ILL.
- WAIT: counts RST_HOLD_TICKS ticks, then moves to RUN with pc=0.
- DONE_OK and DONE_ILL are terminal until reset.
REQ-011 In RUN, on each tick the block SHALL decode rom[pc]:
- if illegal, go to DONE_ILL;
- else if the word equals 0x00100073, go to DONE_OK;
- otherwise increment pc (4 bits). Reaching pc 15 without EBREAK is impossible with this ROM; pc SHALL wrap to 0 if it ever does.
REQ-012 An instruction SHALL be legal only if it is an RV32I base encoding:
- LUI, AUIPC, JAL;
- JALR with funct3=000;
- BRANCH with funct3 not 010/011;
- LOAD with funct3 in {000,001,010,100,101};
- STORE with funct3 in {000,001,010};
- OP-IMM, where SLLI needs funct7=0 and SRLI/SRAI need funct7 in {0,0100000};
- OP with funct7=0, or funct7=0100000 only for ADD/SRL;
- MISC-MEM (opcode 0001111);
- SYSTEM (opcode 1110011).
Every other opcode, including bits[1:0]!=11, SHALL be illegal.
REQ-013 Decode SHALL be combinational on rom[pc]; the state and LED update SHALL occur on the tick edge with no additional latency.
REQ-014 led_o SHALL be registered, with bits assigned as follows:
- [0] heartbeat, toggling every tick in every state;
- [1] state==RUN;
- [4:2] pc[2:0];
- [5] DONE_ILL latched;
- [6] DONE_OK latched;
- [7] state is DONE_OK or DONE_ILL.
REQ-015 led_o[5] and led_o[6] SHALL never be high together.
REQ-016 Once set, led_o[5] and led_o[6] SHALL remain high until reset.

Reset
REQ-017 While rst_sw_i=0 at a clock edge, the block SHALL clear the following: divider=0, WAIT count=0, pc=0, state=WAIT, led_o=8'h00.
REQ-018 Asserting reset mid-RUN or in a DONE state SHALL return all state to the REQ-017 values on the next edge, with no residual latched status.
REQ-019 After rst_sw_i returns to 1, operation SHALL restart exactly as from power-up.

Configuration
REQ-020 When macro FAULT_INJECT_EN is defined, ROM word FAULT_INDEX SHALL read as 0x00000000, which is illegal, and execution SHALL end in DONE_ILL at that index.
REQ-021 When FAULT_INJECT_EN is undefined, the ROM SHALL be exactly as in REQ-009 and FAULT_INDEX SHALL have no effect.

Verification
REQ-022 The bench SHALL cover these directed scenarios with default parameters:
- No macro, reset held low 500 cycles then released: led_o[6]=1 and led_o[7]=1 on clock edge 80 after release (tick 20); led_o[5] stays 0.
- FAULT_INJECT_EN with FAULT_INDEX=5: led_o[5]=1 on edge 40 after release (tick 10); led_o[4:2]=3'b101; led_o[6]=0.
- Reset pulled low at edge 50 of a run: led_o=8'h00 on the next edge; after re-release, led_o[6] rises 80 edges later.
- Heartbeat check: led_o[0] toggles every 4 clocks from edge 4 after release; led_o[1] rises at edge 16 (tick 4).
- Decoder unit check: the following words are legal — 0x00000013, 0x40208233, 0x00100073. The following are illegal — 0x00000000, 0x0000707F, 0x02208033 (M-extension).
